// File: rtl/issue_select.sv
// Age-ordered issue selector: picks up to NUM_FU ready RS entries, oldest first,
// into per-FU issue registers, with branch-mask kill/resolve and a handshake counter.
module issue_select #(
  parameter int NUM_RS  = 16,
  parameter int NUM_FU  = 2,
  parameter int ENTRY_W = 64,
  parameter int AGE_W   = 6,
  parameter int BMASK_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic                                      clock,
  input  logic                                      reset_n,
  input  logic [NUM_RS-1:0]                         rs_valid,
  input  logic [NUM_RS-1:0]                         rs_src_ready,
  input  logic [NUM_RS-1:0][AGE_W-1:0]              rs_age,
  input  logic [NUM_RS-1:0][BMASK_W-1:0]            rs_bmask,
  input  logic [NUM_RS-1:0][ENTRY_W-1:0]            rs_payload,
  input  logic [NUM_FU-1:0]                         fu_ready,
  input  logic [BMASK_W-1:0]                        br_resolve,
  input  logic [BMASK_W-1:0]                        br_kill,
  output logic [NUM_FU-1:0]                         clear_valid,
  output logic [NUM_FU-1:0][$clog2(NUM_RS)-1:0]     clear_idx,
  output logic [NUM_FU-1:0]                         issue_valid,
  output logic [NUM_FU-1:0][ENTRY_W-1:0]            issue_payload,
  output logic [NUM_FU-1:0][BMASK_W-1:0]            issue_bmask,
  output logic [CNT_W-1:0]                          issued_count
);

  localparam int IDX_W  = $clog2(NUM_RS);
  localparam int RANK_W = $clog2(NUM_RS + 1);
  localparam int HS_W   = $clog2(NUM_FU + 1);

  logic [NUM_RS-1:0]             cand_p0;
  logic [NUM_RS-1:0][RANK_W-1:0] rank_p0;
  logic [NUM_FU-1:0]             slot_free_p0;
  logic [NUM_FU-1:0]             sel_vld_p0;
  logic [NUM_FU-1:0][IDX_W-1:0]  sel_idx_p0;
  logic [HS_W-1:0]               hs_p0;

  // Modulo-age comparison; ties broken in favour of the lower RS index.
  function automatic logic older(input logic [AGE_W-1:0] a,
                                 input logic [AGE_W-1:0] b,
                                 input logic             lower_idx);
    logic [AGE_W-1:0] d;
    d = a - b;
    if (a == b) return lower_idx;
    return d[AGE_W-1];
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [HS_W-1:0]  n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(n);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Stage p0: candidate filter, age rank, slot assignment (combinational)
  always_comb begin
    for (int i = 0; i < NUM_RS; i++)
      cand_p0[i] = rs_valid[i] & rs_src_ready[i] & ~(|(rs_bmask[i] & br_kill));
  end

  // Rank = number of candidates older than this one; ranks are unique.
  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      rank_p0[i] = '0;
      for (int j = 0; j < NUM_RS; j++)
        if (j != i && cand_p0[j] && older(rs_age[j], rs_age[i], j < i))
          rank_p0[i] = rank_p0[i] + RANK_W'(1);
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FU; f++)
      slot_free_p0[f] = ~issue_valid[f] | fu_ready[f] | (|(issue_bmask[f] & br_kill));
  end

  // The k-th free slot (ascending) takes the candidate of rank k.
  always_comb begin
    logic [RANK_W-1:0] frank;
    frank      = '0;
    sel_vld_p0 = '0;
    sel_idx_p0 = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (slot_free_p0[f]) begin
        for (int i = 0; i < NUM_RS; i++) begin
          if (cand_p0[i] && rank_p0[i] == frank) begin
            sel_vld_p0[f] = 1'b1;
            sel_idx_p0[f] = IDX_W'(i);
          end
        end
        frank = frank + RANK_W'(1);
      end
    end
  end

  always_comb begin
    hs_p0 = '0;
    for (int f = 0; f < NUM_FU; f++)
      hs_p0 = hs_p0 + HS_W'(issue_valid[f] & fu_ready[f]);
  end

  assign clear_valid = reset_n ? sel_vld_p0 : '0;
  assign clear_idx   = reset_n ? sel_idx_p0 : '0;

  // Stage p1: issue registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issue_valid   <= '0;
      issue_payload <= '0;
      issue_bmask   <= '0;
      issued_count  <= '0;
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (sel_vld_p0[f]) begin
          issue_valid[f]   <= 1'b1;
          issue_payload[f] <= rs_payload[sel_idx_p0[f]];
          issue_bmask[f]   <= rs_bmask[sel_idx_p0[f]] & ~br_resolve;
        end else begin
          if (slot_free_p0[f]) issue_valid[f] <= 1'b0;
          issue_bmask[f] <= issue_bmask[f] & ~br_resolve;
        end
      end
      issued_count <= sat_add(issued_count, hs_p0);
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// Randomized check of issue_select against an in-bench selection model, plus
// directed cases for reset, age order, wrap, back-pressure, kill/resolve, saturation.
module tb_issue_select;
  localparam int NRS = 16;
  localparam int NFU = 2;
  localparam int EW  = 64;
  localparam int AW  = 6;
  localparam int BW  = 4;

  logic                     clock = 1'b0;
  logic                     reset_n;
  logic [NRS-1:0]           rs_valid, rs_src_ready;
  logic [NRS-1:0][AW-1:0]   rs_age;
  logic [NRS-1:0][BW-1:0]   rs_bmask;
  logic [NRS-1:0][EW-1:0]   rs_payload;
  logic [NFU-1:0]           fu_ready;
  logic [BW-1:0]            br_resolve, br_kill;

  logic [NFU-1:0]           clear_valid, clear_valid_s;
  logic [NFU-1:0][3:0]      clear_idx, clear_idx_s;
  logic [NFU-1:0]           issue_valid, issue_valid_s;
  logic [NFU-1:0][EW-1:0]   issue_payload, issue_payload_s;
  logic [NFU-1:0][BW-1:0]   issue_bmask, issue_bmask_s;
  logic [31:0]              issued_count;
  logic [3:0]               issued_count_s;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_iv [NFU];
  logic [63:0] m_pay[NFU];
  logic [3:0]  m_bm [NFU];
  longint      m_cnt;
  int          m_cnt_s;
  logic [1:0]  m_cv;
  int          m_ci [NFU];

  always #5 clock = ~clock;

  issue_select #(.NUM_RS(NRS), .NUM_FU(NFU), .ENTRY_W(EW), .AGE_W(AW), .BMASK_W(BW), .CNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .rs_valid(rs_valid), .rs_src_ready(rs_src_ready),
    .rs_age(rs_age), .rs_bmask(rs_bmask), .rs_payload(rs_payload), .fu_ready(fu_ready),
    .br_resolve(br_resolve), .br_kill(br_kill), .clear_valid(clear_valid), .clear_idx(clear_idx),
    .issue_valid(issue_valid), .issue_payload(issue_payload), .issue_bmask(issue_bmask),
    .issued_count(issued_count));

  issue_select #(.NUM_RS(NRS), .NUM_FU(NFU), .ENTRY_W(EW), .AGE_W(AW), .BMASK_W(BW), .CNT_W(4)) dut_s (
    .clock(clock), .reset_n(reset_n), .rs_valid(rs_valid), .rs_src_ready(rs_src_ready),
    .rs_age(rs_age), .rs_bmask(rs_bmask), .rs_payload(rs_payload), .fu_ready(fu_ready),
    .br_resolve(br_resolve), .br_kill(br_kill), .clear_valid(clear_valid_s), .clear_idx(clear_idx_s),
    .issue_valid(issue_valid_s), .issue_payload(issue_payload_s), .issue_bmask(issue_bmask_s),
    .issued_count(issued_count_s));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // a older than b: (age_a - age_b) mod 64 lies in the upper half
  function automatic bit m_older(input int ia, input int ib);
    int d;
    d = (int'(rs_age[ia]) - int'(rs_age[ib]) + 64) % 64;
    if (d == 0) return ia < ib;
    return d >= 32;
  endfunction

  task automatic model_reset();
    for (int f = 0; f < NFU; f++) begin
      m_iv[f] = 0; m_pay[f] = '0; m_bm[f] = '0;
    end
    m_cnt = 0; m_cnt_s = 0;
  endtask

  // Selection for the current inputs, DUT clear outputs compared, state advanced one edge.
  task automatic model_cycle();
    int cl[$];
    int order[$];
    int nxt, hs, idx;
    bit free;
    for (int i = 0; i < NRS; i++)
      if (rs_valid[i] && rs_src_ready[i] && ((rs_bmask[i] & br_kill) == 0)) cl.push_back(i);
    while (cl.size() > 0) begin
      int b;
      b = 0;
      for (int k = 1; k < cl.size(); k++) if (m_older(cl[k], cl[b])) b = k;
      order.push_back(cl[b]);
      cl.delete(b);
    end
    hs = 0;
    for (int f = 0; f < NFU; f++) if (m_iv[f] && fu_ready[f]) hs++;
    nxt = 0;
    m_cv = '0;
    for (int f = 0; f < NFU; f++) begin
      free = !m_iv[f] || fu_ready[f] || ((m_bm[f] & br_kill) != 0);
      m_ci[f] = 0;
      if (free && nxt < order.size()) begin
        idx = order[nxt]; nxt++;
        m_cv[f] = 1'b1; m_ci[f] = idx;
        m_iv[f] = 1; m_pay[f] = rs_payload[idx]; m_bm[f] = rs_bmask[idx] & ~br_resolve;
      end else begin
        if (free) m_iv[f] = 0;
        m_bm[f] = m_bm[f] & ~br_resolve;
      end
    end
    chk("clear_valid", clear_valid, m_cv);
    for (int f = 0; f < NFU; f++) if (m_cv[f]) chk("clear_idx", clear_idx[f], m_ci[f]);
    m_cnt += hs;
    m_cnt_s = (m_cnt_s + hs > 15) ? 15 : m_cnt_s + hs;
  endtask

  task automatic clear_inputs();
    rs_valid = '0; rs_src_ready = '0; fu_ready = '0; br_kill = '0; br_resolve = '0;
    for (int i = 0; i < NRS; i++) begin
      rs_age[i] = '0; rs_bmask[i] = '0; rs_payload[i] = 64'h1000 + 64'(i);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    // reset with every entry ready, then a full-throughput stream
    reset_n = 1'b0;
    clear_inputs();
    rs_valid = '1; rs_src_ready = '1; fu_ready = 2'b11;
    for (int i = 0; i < NRS; i++) rs_age[i] = AW'(i);
    repeat (2) @(negedge clock);
    #1;
    chk("rst_clear_valid", clear_valid, 0);
    chk("rst_clear_idx", clear_idx, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_payload0", issue_payload[0], 0);
    chk("rst_bmask", issue_bmask, 0);
    chk("rst_count", issued_count, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_clear_valid", clear_valid, 2'b11);
    chk("rel_clear_idx0", clear_idx[0], 0);
    chk("rel_clear_idx1", clear_idx[1], 1);
    @(posedge clock); #1;
    chk("c1_issue_valid", issue_valid, 2'b11);
    chk("c1_payload0", issue_payload[0], 64'h1000);
    chk("c1_payload1", issue_payload[1], 64'h1001);
    chk("c1_count", issued_count, 0);
    repeat (3) @(posedge clock); #1;
    chk("stream_count6", issued_count, 6);
    repeat (4) @(posedge clock); #1;
    chk("sat_count14", issued_count_s, 14);
    @(posedge clock); #1;
    chk("sat_count15", issued_count_s, 15);
    chk("wide_count16", issued_count, 16);
    @(posedge clock); #1;
    chk("sat_hold15", issued_count_s, 15);
    chk("wide_count18", issued_count, 18);

    // age order with a tie, then stall and single-slot back-pressure
    clear_inputs(); apply_reset();
    rs_valid = 16'h008A; rs_src_ready = 16'h008A;
    rs_age[3] = 6'd10; rs_age[7] = 6'd5; rs_age[1] = 6'd5;
    model_reset();
    #1;
    model_cycle();
    chk("model_age_slot0", m_ci[0], 1);
    chk("model_age_slot1", m_ci[1], 7);
    chk("age_idx0", clear_idx[0], 1);
    chk("age_idx1", clear_idx[1], 7);
    @(negedge clock);
    rs_valid = 16'h0008; rs_src_ready = 16'h0008; fu_ready = 2'b00;
    #1;
    chk("stall_clear_valid", clear_valid, 0);
    @(negedge clock);
    fu_ready = 2'b01;
    #1;
    chk("bp_clear_valid", clear_valid, 2'b01);
    chk("bp_clear_idx0", clear_idx[0], 3);
    @(posedge clock); #1;
    chk("bp_issue_valid", issue_valid, 2'b11);
    chk("bp_payload0", issue_payload[0], 64'h1003);
    chk("bp_payload1_held", issue_payload[1], 64'h1007);
    chk("bp_count", issued_count, 1);

    // age wrap
    clear_inputs(); apply_reset();
    rs_valid = 16'h0003; rs_src_ready = 16'h0003;
    rs_age[0] = 6'd62; rs_age[1] = 6'd1;
    model_reset();
    #1;
    model_cycle();
    chk("model_wrap_slot0", m_ci[0], 0);
    chk("wrap_idx0", clear_idx[0], 0);
    chk("wrap_idx1", clear_idx[1], 1);

    // kill and resolve
    clear_inputs(); apply_reset();
    rs_valid = 16'h0024; rs_src_ready = 16'h0024;
    rs_bmask[2] = 4'b0010; rs_age[2] = 6'd0;
    rs_bmask[5] = 4'b0100; rs_age[5] = 6'd1;
    @(posedge clock); #1;
    chk("kr_bmask0", issue_bmask[0], 4'b0010);
    chk("kr_bmask1", issue_bmask[1], 4'b0100);
    @(negedge clock);
    clear_inputs();
    rs_valid = 16'h0200; rs_src_ready = 16'h0200; rs_bmask[9] = 4'b0010; rs_age[9] = 6'd2;
    br_kill = 4'b0010; br_resolve = 4'b0100;
    #1;
    chk("kr_no_select", clear_valid, 0);
    @(posedge clock); #1;
    chk("kr_issue_valid", issue_valid, 2'b10);
    chk("kr_bmask1_resolved", issue_bmask[1], 4'b0000);

    // randomized run against the model, with occasional async reset
    clear_inputs(); apply_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      for (int f = 0; f < NFU; f++) begin
        chk("rnd_issue_valid", issue_valid[f], m_iv[f]);
        if (m_iv[f]) begin
          chk("rnd_payload", issue_payload[f], m_pay[f]);
          chk("rnd_bmask", issue_bmask[f], m_bm[f]);
        end
      end
      chk("rnd_count", issued_count, m_cnt[31:0]);
      chk("rnd_count_sat", issued_count_s, m_cnt_s);
      reset_n = ($urandom_range(0, 99) != 0);
      rs_valid = NRS'($urandom); rs_src_ready = NRS'($urandom);
      base = $urandom_range(0, 63);
      for (int i = 0; i < NRS; i++) begin
        rs_age[i] = AW'((base + $urandom_range(0, 30)) % 64);
        rs_bmask[i] = ($urandom_range(0, 1) != 0) ? BW'($urandom) : '0;
        rs_payload[i] = {$urandom, $urandom};
      end
      fu_ready = NFU'($urandom);
      br_kill = ($urandom_range(0, 7) == 0) ? BW'(1 << $urandom_range(0, BW-1)) : '0;
      br_resolve = ($urandom_range(0, 3) == 0) ? BW'($urandom) : '0;
      #1;
      if (!reset_n) begin
        model_reset();
        chk("rnd_rst_clear", clear_valid, 0);
      end else begin
        model_cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/issue_select.md
# issue_select

Parametrised, age-ordered issue selector for one functional-unit class, sitting between a reservation-station bank and its `NUM_FU` execution units. Each cycle it picks up to `NUM_FU` operand-ready RS entries, oldest first, and latches them into per-FU issue registers. It tells the RS which entries left and holds an issued entry while its FU back-pressures. Mispredicts flush it selectively by branch mask, and resolved branches clear mask bits.

## Interface
- `NUM_RS`, 16: RS entries watched.
- `NUM_FU`, 2: FUs / issue slots.
- `ENTRY_W`, 64: opaque payload bits per entry.
- `AGE_W`, 6: age tag width; wraps modulo 2^AGE_W.
- `BMASK_W`, 4: branch-mask width.
- `CNT_W`, 32: issued-instruction counter width.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rs_valid` in NUM_RS: entry occupied.
- `rs_src_ready` in NUM_RS: all operands ready.
- `rs_age` in NUM_RS×AGE_W: dispatch sequence tag.
- `rs_bmask` in NUM_RS×BMASK_W: unresolved branches the entry depends on.
- `rs_payload` in NUM_RS×ENTRY_W: entry contents.
- `fu_ready` in NUM_FU: FU accepts its slot this cycle.
- `br_resolve` in BMASK_W: branches resolved correctly this cycle.
- `br_kill` in BMASK_W: branches mispredicted this cycle.
- `clear_valid` out NUM_FU: slot f took an RS entry this cycle (combinational).
- `clear_idx` out NUM_FU×$clog2(NUM_RS): RS index taken by slot f.
- `issue_valid` out NUM_FU: slot f holds an instruction (registered).
- `issue_payload` out NUM_FU×ENTRY_W: registered payload.
- `issue_bmask` out NUM_FU×BMASK_W: registered, resolve-updated mask.
- `issued_count` out CNT_W: saturating count of FU handshakes.

## Operation
- Candidate: `rs_valid & rs_src_ready & ((rs_bmask & br_kill) == 0)`.
- Age order: a is older than b iff bit AGE_W-1 of (a − b) mod 2^AGE_W is 1. On equal ages, the lower RS index is older. Correctness requires the in-flight age span < 2^(AGE_W-1).
- Slot free: `!issue_valid[f]`, or `issue_valid[f] & fu_ready[f]`, or slot f killed this cycle.
- Free slots are filled in ascending f order. The oldest candidate goes to the lowest free slot, the next oldest to the next free slot, and so on. A candidate is never selected twice.
- Occupied, non-free slots hold payload unchanged.
- `clear_valid[f]` / `clear_idx[f]` are asserted for every fill. The RS drops those entries at the same edge, so they are never re-presented.
- Kill: held slot with `(issue_bmask[f] & br_kill) != 0` → `issue_valid[f]` = 0 next cycle, unless refilled.
- Resolve: every held and newly captured mask becomes `mask & ~br_resolve` at the edge.
- When `br_kill` and `br_resolve` share a bit, kill wins for that bit.
- `issued_count` +1 per f with `issue_valid[f] & fu_ready[f]` at the edge, so it can add up to NUM_FU per cycle. It saturates at 2^CNT_W − 1.
- `fu_ready` on an empty slot is ignored.

## Timing
- Reset (`reset_n` low, asynchronous) sets `issue_valid` = 0, `issue_payload` = 0, `issue_bmask` = 0, `issued_count` = 0. While reset is asserted, `clear_valid` = 0 and `clear_idx` = 0.
- After reset deasserts, the first selection happens at the first rising edge.
- Latency: an entry ready in cycle N appears on `issue_valid` in cycle N+1, provided a slot is free in N.
- Handshake: a slot transfers on a cycle with `issue_valid & fu_ready`. Payload is stable until then.
- Back-to-back: a slot handing off in cycle N can be refilled in the same cycle, giving one issue per slot per cycle.
- All FUs stalled: no `clear_valid`; candidates remain in the RS.
- Fewer candidates than free slots: the unused higher slots go empty (or stay empty).
- Reset asserted mid-operation drops held instructions immediately and does not update the counter.

## Test plan
- Reset: hold `reset_n` = 0 with every RS entry ready → all outputs 0. Release → cycle 1 `issue_valid` = 2'b11.
- Age order: NUM_FU = 2, ready entries idx3 age 10, idx7 age 5, idx1 age 5 → `clear_idx` = {slot0: 1, slot1: 7}. Next cycle idx3 issues if slots are free.
- Wrap: AGE_W = 6, idx0 age 62, idx1 age 1 → idx0 is oldest → slot0 = idx0.
- Back-pressure: slot0 held, `fu_ready` = 01 → slot0 refilled, slot1 holds the same payload, `issued_count` +1. `fu_ready` = 11 for 3 cycles with continuous supply → `issued_count` +6.
- Kill/resolve: slot0 mask 0010, slot1 mask 0100, `br_kill` = 0010, `br_resolve` = 0100 → next cycle slot0 is invalid and slot1's mask is 0000. An RS entry with mask 0010 is not selected that cycle.
- Saturation: CNT_W = 4, counter at 14, two handshakes in one cycle → 15, and it stays at 15 afterwards.
